// File: rtl/fetch_from_memory.sv
// -----------------------------------------------------------------------------
// fetch_from_memory
//
// Line-fill engine between the instruction/data caches and the SysBus.
// A fetch request (fetch_type INSTRUCTION or DATA) latches the line-aligned
// address, issues one line read on the bus, then collects the response
// beats. Each accepted beat is forwarded to the cache as an
// (address, data, write-strobe) triple one clock later. The strobe of the
// final beat also carries the one-cycle done pulse.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   start_addr                  requested byte address (any alignment)
//   fetch_type                  00 NONE, 01 INSTRUCTION, 10 DATA, 11 NONE
//   bus_reqcyc/bus_req/bus_reqtag  read request (valid, line address, tag)
//   bus_reqack                  bus accepted the request
//   bus_respcyc/bus_resp/bus_resptag  response beat (valid, data, tag)
//   bus_respack                 beat acknowledge (combinational)
//   ofm_fetch_from_memory_done  one-cycle pulse with the last beat strobe
//   ofm_write_to_cache          one-cycle strobe per delivered beat
//   ofm_addr, ofm_data          byte address and data of delivered beat
//
// Build option:
//   FETCH_MEM_TAG_CHECK_EN      when defined, a response beat is accepted
//                               only if bus_resptag equals the read tag;
//                               otherwise bus_resptag is ignored.
// -----------------------------------------------------------------------------
module fetch_from_memory #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BYTES     = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               start_addr,
  input  logic [1:0]                fetch_type,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      ofm_fetch_from_memory_done,
  output logic                      ofm_write_to_cache,
  output logic [63:0]               ofm_addr,
  output logic [BUS_DATA_WIDTH-1:0] ofm_data
);

  localparam int BEATS  = LINE_BYTES * 8 / BUS_DATA_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam logic [63:0]              BEAT_BYTES = 64'(BUS_DATA_WIDTH / 8);
  localparam logic [BEAT_W-1:0]        LAST_BEAT  = BEAT_W'(BEATS - 1);
  // READ in bit 12, MEMORY target (4'b0001) in bits 11:8, low byte zero.
  localparam logic [BUS_TAG_WIDTH-1:0] READ_TAG   = BUS_TAG_WIDTH'(13'h1100);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQUESTING = 2'd1,
    READING    = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [63:0]         line;
  logic [BEAT_W-1:0]   beat;
  logic                start_fill;
  logic                tag_ok;
  logic                beat_ok;
  logic                unused_ok;

  // Only the two real request types start a fill; 11 behaves like NONE.
  assign start_fill = (fetch_type == 2'b01) || (fetch_type == 2'b10);

`ifdef FETCH_MEM_TAG_CHECK_EN
  assign tag_ok = (bus_resptag == READ_TAG);
`else
  assign tag_ok = 1'b1;
`endif

  // A beat counts only while collecting the line; stray beats elsewhere
  // are neither acknowledged nor forwarded.
  assign beat_ok = (state == READING) && bus_respcyc && tag_ok;

  // Offset bits of start_addr are dropped by line alignment; the response
  // tag is unused when tag checking is compiled out.
  assign unused_ok = ^{start_addr[OFF_W-1:0], bus_resptag};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (start_fill) state_next = REQUESTING;
      REQUESTING: if (bus_reqack) state_next = READING;
      READING:    if (beat_ok && (beat == LAST_BEAT)) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Bus-facing outputs: request held stable for the whole REQUESTING state.
  always_comb begin
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    case (state)
      REQUESTING: begin
        bus_reqcyc = 1'b1;
        bus_req    = BUS_DATA_WIDTH'(line);
        bus_reqtag = READ_TAG;
      end
      READING: bus_respack = beat_ok;
      default: ;
    endcase
  end

  // Line latch, beat counter and registered cache-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      line                       <= '0;
      beat                       <= '0;
      ofm_write_to_cache         <= 1'b0;
      ofm_fetch_from_memory_done <= 1'b0;
      ofm_addr                   <= '0;
      ofm_data                   <= '0;
    end else begin
      ofm_write_to_cache         <= 1'b0;
      ofm_fetch_from_memory_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_fill) begin
            line <= {start_addr[63:OFF_W], {OFF_W{1'b0}}};
          end
        end
        REQUESTING: begin
          if (bus_reqack) begin
            beat <= '0;
          end
        end
        READING: begin
          if (beat_ok) begin
            ofm_write_to_cache <= 1'b1;
            ofm_addr           <= line + 64'(beat) * BEAT_BYTES;
            ofm_data           <= bus_resp;
            beat               <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              ofm_fetch_from_memory_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_from_memory.sv
module tb_fetch_from_memory;

  localparam logic [12:0] TAG = 13'h1100;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] start_addr;
  logic [1:0]  fetch_type;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;
  logic        ofm_fetch_from_memory_done;
  logic        ofm_write_to_cache;
  logic [63:0] ofm_addr;
  logic [63:0] ofm_data;

  fetch_from_memory dut (
    .clk(clk),
    .reset(reset),
    .start_addr(start_addr),
    .fetch_type(fetch_type),
    .bus_reqcyc(bus_reqcyc),
    .bus_req(bus_req),
    .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_resp(bus_resp),
    .bus_resptag(bus_resptag),
    .bus_respack(bus_respack),
    .ofm_fetch_from_memory_done(ofm_fetch_from_memory_done),
    .ofm_write_to_cache(ofm_write_to_cache),
    .ofm_addr(ofm_addr),
    .ofm_data(ofm_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Observation of the cache side and bus handshakes, sampled mid-cycle.
  logic [63:0] obs_addr[$];
  logic [63:0] obs_data[$];
  bit          obs_done[$];
  int n_done, n_ack, n_reqcyc, n_bad_ack;

  always @(negedge clk) begin
    if (ofm_write_to_cache) begin
      obs_addr.push_back(ofm_addr);
      obs_data.push_back(ofm_data);
      obs_done.push_back(ofm_fetch_from_memory_done);
    end
    if (ofm_fetch_from_memory_done) n_done++;
    if (bus_respack) n_ack++;
    if (bus_respack && !bus_respcyc) n_bad_ack++;
    if (bus_reqcyc) n_reqcyc++;
  end

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    obs_done.delete();
    n_done = 0; n_ack = 0; n_reqcyc = 0; n_bad_ack = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] beat_tag(input bit special);
`ifdef FETCH_MEM_TAG_CHECK_EN
    return TAG;
`else
    // Tag is ignored: use a foreign tag on the marked beat, random elsewhere.
    return special ? 13'h0100 : 13'($urandom);
`endif
  endfunction

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  ftype;
    int          ack_delay;
    int          gap_pos;
    int          gap_len;
    int          bad_pos;
    bit          chg;
    bit          rnd;
    bit          exp_fill;
    logic [63:0] exp_line;
  } vec_t;

  function automatic vec_t mk(input logic [63:0] addr, input logic [1:0] ftype,
                              input int ack_delay, input int gap_pos, input int gap_len,
                              input int bad_pos, input bit chg, input bit rnd,
                              input bit exp_fill, input logic [63:0] exp_line);
    vec_t v;
    v.addr = addr; v.ftype = ftype; v.ack_delay = ack_delay;
    v.gap_pos = gap_pos; v.gap_len = gap_len; v.bad_pos = bad_pos;
    v.chg = chg; v.rnd = rnd; v.exp_fill = exp_fill; v.exp_line = exp_line;
    return v;
  endfunction

  task automatic do_fill(input vec_t v, input string name);
    logic [63:0] dat [8];
    logic [7:0]  done_vec;
    clear_obs();
    for (int i = 0; i < 8; i++) dat[i] = v.rnd ? {$urandom, $urandom} : 64'hA0 + 64'(i);
    start_addr = v.addr;
    fetch_type = v.ftype;
    cyc();
    fetch_type = 2'b00;
    start_addr = {$urandom, $urandom};
    for (int d = 0; d <= v.ack_delay; d++) begin
      bus_reqack = (d == v.ack_delay);
      #1;
      check({name, " reqcyc"}, 64'(bus_reqcyc), 64'd1);
      check({name, " req addr"}, bus_req, v.exp_line);
      check({name, " req tag"}, 64'(bus_reqtag), 64'(TAG));
      cyc();
    end
    bus_reqack = 1'b0;
    check({name, " reqcyc drop"}, 64'(bus_reqcyc), 64'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == v.gap_pos) repeat (v.gap_len) cyc();
`ifdef FETCH_MEM_TAG_CHECK_EN
      if (i == v.bad_pos) begin
        bus_respcyc = 1'b1; bus_resp = 64'hDEAD_BEEF; bus_resptag = 13'h0100;
        #1;
        check({name, " bad tag ack"}, 64'(bus_respack), 64'd0);
        cyc();
        bus_respcyc = 1'b0;
      end
`endif
      bus_respcyc = 1'b1;
      bus_resp    = dat[i];
      bus_resptag = beat_tag(i == v.bad_pos);
      if (v.chg && i == 3) begin
        start_addr = 64'h8000;
        fetch_type = 2'b10;
      end
      #1;
      check($sformatf("%s respack %0d", name, i), 64'(bus_respack), 64'd1);
      cyc();
      bus_respcyc = 1'b0;
    end
    fetch_type = 2'b00;
    cyc();
    cyc();
    check({name, " strobes"}, 64'(obs_addr.size()), 64'd8);
    done_vec = '0;
    for (int i = 0; i < 8 && i < obs_addr.size(); i++) begin
      check($sformatf("%s addr %0d", name, i), obs_addr[i], v.exp_line + 64'(8 * i));
      check($sformatf("%s data %0d", name, i), obs_data[i], dat[i]);
      done_vec[i] = obs_done[i];
    end
    check({name, " done pos"}, 64'(done_vec), 64'h80);
    check({name, " done cnt"}, 64'(n_done), 64'd1);
    check({name, " ack cnt"}, 64'(n_ack), 64'd8);
    check({name, " reqcyc cnt"}, 64'(n_reqcyc), 64'(v.ack_delay + 1));
    check({name, " stray ack"}, 64'(n_bad_ack), 64'd0);
  endtask

  task automatic idle_type(input vec_t v, input string name);
    clear_obs();
    start_addr = v.addr;
    fetch_type = v.ftype;
    bus_respcyc = 1'b1;
    bus_resptag = TAG;
    repeat (20) cyc();
    fetch_type = 2'b00;
    bus_respcyc = 1'b0;
    cyc();
    check({name, " reqcyc cnt"}, 64'(n_reqcyc), 64'd0);
    check({name, " strobes"}, 64'(obs_addr.size()), 64'd0);
    check({name, " ack cnt"}, 64'(n_ack), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " reqcyc"}, 64'(bus_reqcyc), 64'd0);
    check({name, " req"}, bus_req, 64'd0);
    check({name, " reqtag"}, 64'(bus_reqtag), 64'd0);
    check({name, " respack"}, 64'(bus_respack), 64'd0);
    check({name, " write"}, 64'(ofm_write_to_cache), 64'd0);
    check({name, " done"}, 64'(ofm_fetch_from_memory_done), 64'd0);
    check({name, " addr"}, ofm_addr, 64'd0);
    check({name, " data"}, ofm_data, 64'd0);
  endtask

  task automatic reset_mid_fill();
    int acks_before;
    clear_obs();
    start_addr = 64'h1234;
    fetch_type = 2'b01;
    cyc();
    fetch_type = 2'b00;
    bus_reqack = 1'b1;
    cyc();
    bus_reqack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_respcyc = 1'b1; bus_resp = 64'hB0 + 64'(i); bus_resptag = TAG;
      cyc();
      bus_respcyc = 1'b0;
    end
    reset = 1'b1;
    bus_respcyc = 1'b1; bus_resp = 64'hB3; bus_resptag = TAG;
    cyc();
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    acks_before = n_ack;
    repeat (3) cyc();
    bus_respcyc = 1'b0;
    cyc();
    check("midreset acks after", 64'(n_ack - acks_before), 64'd0);
    check("midreset strobes", 64'(obs_addr.size()), 64'd3);
    check("midreset done", 64'(n_done), 64'd0);
  endtask

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(64'h1234, 2'b01, 2, -1, 0, -1, 1'b0, 1'b0, 1'b1, 64'h1200);
    tbl[1] = mk(64'h1234, 2'b01, 2,  4, 3, -1, 1'b0, 1'b0, 1'b1, 64'h1200);
    tbl[2] = mk(64'h0000, 2'b00, 0, -1, 0, -1, 1'b0, 1'b0, 1'b0, 64'h0);
    tbl[3] = mk(64'h5678, 2'b11, 0, -1, 0, -1, 1'b0, 1'b0, 1'b0, 64'h0);
    tbl[4] = mk(64'h1234, 2'b10, 0, -1, 0, -1, 1'b1, 1'b1, 1'b1, 64'h1200);
    tbl[5] = mk(64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 0, 6, 1, -1, 1'b0, 1'b1, 1'b1,
                64'hFFFF_FFFF_FFFF_FFC0);
    tbl[6] = mk(64'h1240, 2'b01, 1, -1, 0, 2, 1'b0, 1'b1, 1'b1, 64'h1240);
    tbl[7] = mk(64'h103F, 2'b01, 3, 0, 2, 7, 1'b0, 1'b1, 1'b1, 64'h1000);

    reset = 1'b1;
    start_addr = '0; fetch_type = 2'b00; bus_reqack = 1'b0;
    bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    cyc();
    cyc();
    check_all_zero("reset");
    reset = 1'b0;
    cyc();

    for (int k = 0; k < 8; k++) begin
      if (tbl[k].exp_fill) do_fill(tbl[k], $sformatf("vec%0d", k));
      else idle_type(tbl[k], $sformatf("vec%0d", k));
    end

    reset_mid_fill();

    for (int r = 0; r < 8; r++) begin
      vec_t v;
      logic [63:0] a;
      a = {$urandom, $urandom};
      v = mk(a, 2'($urandom_range(1, 2)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1, 1'b1,
             a & ~64'h3F);
      do_fill(v, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
